// File: rtl/rv_ifetch.sv
// Instruction fetch stage: owns the PC, issues word fetches with credit-based flow control,
// and buffers {instruction, pc} pairs in a small FIFO feeding the decoder.
module rv_ifetch #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int               FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [WIDTH-1:0] imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [WIDTH-1:0] imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [WIDTH-1:0] inst_data,
   output logic [WIDTH-1:0] inst_pc
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {S_BOOT, S_RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] rsp_pc;
   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    drop_cnt;
   logic [CW-1:0]    count;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
   logic [WIDTH-1:0] pc_mem   [FIFO_DEPTH];

   logic [CW:0]      credit_used;
   logic             req_fire;
   logic             rsp_fire;
   logic             rsp_keep;
   logic             pop;
   logic [CW-1:0]    out_after_rsp;
   logic [WIDTH-1:0] redirect_aligned;
   logic             redirect_lo_unused;

   // Credit counts every slot that is or will be occupied; a same-cycle pop does not free one.
   assign credit_used    = {1'b0, outstanding} + {1'b0, count};
   assign imem_req_valid = (state == S_RUN) && !redirect_valid &&
                           (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored outright.
   assign rsp_fire      = imem_rsp_valid && (outstanding != '0);
   assign rsp_keep      = rsp_fire && (drop_cnt == '0) && !redirect_valid;
   assign out_after_rsp = outstanding - CW'(rsp_fire);

   assign inst_valid = (count != '0) && !redirect_valid;
   assign pop        = inst_valid && inst_ready;
   assign inst_data  = (count != '0) ? data_mem[rd_ptr] : '0;
   assign inst_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;

   assign redirect_aligned   = {redirect_pc[WIDTH-1:2], 2'b00};
   assign redirect_lo_unused = ^redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_BOOT;
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (state == S_BOOT) state <= S_RUN;
         outstanding <= out_after_rsp + CW'(req_fire);
         if (redirect_valid) begin
            // Everything still in flight after this cycle's response becomes stale.
            pc       <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            drop_cnt <= out_after_rsp;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (req_fire) pc <= pc + WIDTH'(4);
            if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            if (rsp_keep) begin
               rsp_pc <= rsp_pc + WIDTH'(4);
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(rsp_keep) - CW'(pop);
         end
      end
   end

   // FIFO storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (rsp_keep) begin
         data_mem[wr_ptr] <= imem_rsp_data;
         pc_mem[wr_ptr]   <= rsp_pc;
      end
   end

endmodule

// File: tb/tb_rv_ifetch.sv
// Scoreboard bench for rv_ifetch: stimulus queues expected {pc, data} pairs, monitors pop and
// compare on each decoder handshake; a second instance covers PC wrap from a high RESET_PC.
module tb_rv_ifetch;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, inst_pc;

   logic        w_rst;
   logic        w_req_valid, w_req_ready, w_rsp_valid;
   logic [31:0] w_req_addr, w_rsp_data;
   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic        w_inst_valid, w_inst_ready;
   logic [31:0] w_inst_data, w_inst_pc;

   rv_ifetch #(.WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc)
   );

   rv_ifetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
      .clk(clk), .rst(w_rst),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
      .imem_req_addr(w_req_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
      .inst_data(w_inst_data), .inst_pc(w_inst_pc)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   inst_t exp_q[$];
   inst_t exp_w[$];
   mreq_t mq[$];
   int    cyc = 0;
   int    lat = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic expect_inst(input logic [31:0] pc, input logic [31:0] data);
      inst_t e;
      e.pc = pc;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // Main memory model: in-order responses, lat cycles after acceptance, cleared by rst.
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk);
      if (rst) mq.delete();
      else if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
   end

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // Single-cycle memory for the wrap instance.
   logic        w_acc = 1'b0;
   logic [31:0] w_acc_addr = '0;
   initial forever begin
      @(negedge clk);
      w_acc      = !w_rst && w_req_valid && w_req_ready;
      w_acc_addr = w_req_addr;
   end
   initial begin
      w_rsp_valid = 1'b0;
      w_rsp_data  = '0;
      forever begin
         @(posedge clk); #1;
         w_rsp_valid = w_acc;
         w_rsp_data  = mem_word(w_acc_addr);
      end
   end

   // Monitors: compare every delivered instruction against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_inst: got pc %h, expected no delivery", inst_pc);
         end else begin
            inst_t e;
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst_data", inst_data, e.data);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (w_inst_valid === 1'b1 && w_inst_ready === 1'b1) begin
         if (exp_w.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_w_inst: got pc %h, expected no delivery", w_inst_pc);
         end else begin
            inst_t e;
            e = exp_w.pop_front();
            chk("w_inst_pc", w_inst_pc, e.pc);
            chk("w_inst_data", w_inst_data, e.data);
         end
      end
   end

   // Ends at the negedge of the first cycle after rst falls.
   task automatic do_reset();
      tick(); rst = 1'b1; redirect_valid = 1'b0;
      neg();
      tick(); neg();
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      tick(); rst = 1'b0;
      neg();
      chk("boot_req_valid", imem_req_valid, 1'b0);
      chk("boot_inst_valid", inst_valid, 1'b0);
   endtask

   // Accept n instructions, then drop inst_ready; ends at a negedge.
   task automatic drain(input int n, output int cycles);
      int got;
      got = 0;
      cycles = 0;
      while (got < n && cycles < 64) begin
         tick(); inst_ready = 1'b1;
         neg(); cycles++;
         if (inst_valid) got++;
      end
      tick(); inst_ready = 1'b0;
      neg();
      if (got < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d instructions, expected %0d", got, n);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      int acc;
      rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      inst_ready = 1'b0;
      w_rst = 1'b1; w_req_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0;
      w_inst_ready = 1'b0;

      // Streaming with a 1-cycle memory
      lat = 1;
      do_reset();
      for (int i = 0; i < 8; i++) expect_inst(32'(i * 4), mem_word(32'(i * 4)));
      tick(); inst_ready = 1'b1; neg();
      chk("t1_req_valid", imem_req_valid, 1'b1);
      chk("t1_req_addr", imem_req_addr, 32'h0);
      chk("t1_inst_valid_r1", inst_valid, 1'b0);
      tick(); neg();
      chk("t1_inst_valid_r2", inst_valid, 1'b0);
      chk("t1_req_addr2", imem_req_addr, 32'h4);
      drain(8, c);
      chk("t1_throughput_cycles", c, 8);
      chk("t1_queue_empty", exp_q.size(), 0);

      // Backpressure fills credit
      do_reset();
      acc = 0;
      for (int i = 0; i < 11; i++) begin
         tick(); neg();
         if (imem_req_valid && imem_req_ready) acc++;
      end
      chk("t2_req_count", acc, 4);
      chk("t2_req_stalled", imem_req_valid, 1'b0);
      chk("t2_head_valid", inst_valid, 1'b1);
      chk("t2_head_pc", inst_pc, 32'h0);
      for (int i = 0; i < 6; i++) expect_inst(32'(i * 4), mem_word(32'(i * 4)));
      tick(); inst_ready = 1'b1; neg();
      chk("t2_no_credit_on_pop", imem_req_valid, 1'b0);
      tick(); neg();
      chk("t2_resume_valid", imem_req_valid, 1'b1);
      chk("t2_resume_addr", imem_req_addr, 32'h10);
      drain(4, c);
      chk("t2_queue_empty", exp_q.size(), 0);

      // Redirect with two stale fetches in flight, 3-cycle memory
      lat = 3;
      do_reset();
      tick(); neg();
      tick(); neg();
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; neg();
      chk("t3_redir_req_valid", imem_req_valid, 1'b0);
      chk("t3_redir_inst_valid", inst_valid, 1'b0);
      tick(); redirect_valid = 1'b0; neg();
      chk("t3_req_valid", imem_req_valid, 1'b1);
      chk("t3_req_addr", imem_req_addr, 32'h100);
      chk("t3_empty_r4", inst_valid, 1'b0);
      tick(); neg();
      chk("t3_empty_r5", inst_valid, 1'b0);
      tick(); neg();
      chk("t3_empty_r6", inst_valid, 1'b0);
      expect_inst(32'h100, 32'hA5A5_0100);
      expect_inst(32'h104, 32'hA5A5_0104);
      drain(2, c);
      chk("t3_queue_empty", exp_q.size(), 0);

      // Redirect colliding with a response and a decoder handshake
      lat = 1;
      do_reset();
      expect_inst(32'h0, 32'hA5A5_0000);
      expect_inst(32'h4, 32'hA5A5_0004);
      expect_inst(32'h200, 32'hA5A5_0200);
      expect_inst(32'h204, 32'hA5A5_0204);
      tick(); inst_ready = 1'b1; neg();
      for (int i = 0; i < 3; i++) begin tick(); neg(); end
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0202; neg();
      chk("t4_redir_inst_valid", inst_valid, 1'b0);
      chk("t4_redir_req_valid", imem_req_valid, 1'b0);
      tick(); redirect_valid = 1'b0; neg();
      chk("t4_req_valid", imem_req_valid, 1'b1);
      chk("t4_req_addr", imem_req_addr, 32'h200);
      chk("t4_inst_valid_r6", inst_valid, 1'b0);
      tick(); neg();
      chk("t4_inst_valid_r7", inst_valid, 1'b0);
      tick(); neg();
      tick(); neg();
      tick(); inst_ready = 1'b0; neg();
      chk("t4_queue_empty", exp_q.size(), 0);

      // Reset with three buffered entries and one outstanding
      do_reset();
      for (int i = 0; i < 4; i++) begin tick(); neg(); end
      tick(); rst = 1'b1; neg();
      chk("t6_pre_inst_valid", inst_valid, 1'b1);
      tick(); neg();
      chk("t6_rst_inst_valid", inst_valid, 1'b0);
      chk("t6_rst_req_valid", imem_req_valid, 1'b0);
      tick(); neg();
      tick(); rst = 1'b0; neg();
      chk("t6_boot_req_valid", imem_req_valid, 1'b0);
      tick(); neg();
      chk("t6_restart_valid", imem_req_valid, 1'b1);
      chk("t6_restart_addr", imem_req_addr, 32'h0);
      expect_inst(32'h0, 32'hA5A5_0000);
      expect_inst(32'h4, 32'hA5A5_0004);
      drain(2, c);
      chk("t6_queue_empty", exp_q.size(), 0);

      // PC wrap from RESET_PC = 0xFFFF_FFF8
      exp_w.push_back('{32'hFFFF_FFF8, 32'h5A5A_FFF8});
      exp_w.push_back('{32'hFFFF_FFFC, 32'h5A5A_FFFC});
      exp_w.push_back('{32'h0000_0000, 32'hA5A5_0000});
      exp_w.push_back('{32'h0000_0004, 32'hA5A5_0004});
      neg();
      chk("t5_rst_req_addr", w_req_addr, 32'hFFFF_FFF8);
      chk("t5_rst_req_valid", w_req_valid, 1'b0);
      tick(); w_rst = 1'b0; w_inst_ready = 1'b1; neg();
      chk("t5_boot_req_valid", w_req_valid, 1'b0);
      tick(); neg();
      chk("t5_req0_addr", w_req_addr, 32'hFFFF_FFF8);
      tick(); neg();
      chk("t5_req1_addr", w_req_addr, 32'hFFFF_FFFC);
      tick(); neg();
      chk("t5_req2_addr", w_req_addr, 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin tick(); neg(); end
      tick(); w_inst_ready = 1'b0; neg();
      chk("t5_queue_empty", exp_w.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_ifetch.md
Name: rv_ifetch

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word-aligned read requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instruction words, each paired with its PC, in a small FIFO that feeds the decoder over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

Parameters:
- WIDTH, 32, data and address width in bits.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, instruction FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  WIDTH  fetch address (the current PC), bits [1:0] always 0.
- imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance, and cannot be back-pressured.
- imem_rsp_data  in  WIDTH  instruction word.
- redirect_valid  in  1  single-cycle redirect strobe.
- redirect_pc  in  WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  FIFO head valid toward the decoder.
- inst_ready  in  1  decoder accepts the head.
- inst_data  out  WIDTH  instruction word at the FIFO head.
- inst_pc  out  WIDTH  PC of inst_data.

Behaviour:
- State:
  - pc: next request address.
  - rsp_pc: PC of the next live response.
  - outstanding: accepted requests not yet responded to, live or stale.
  - drop_cnt: stale responses still to be discarded.
  - FIFO: count, rd_ptr, wr_ptr, entries of {data, pc}.
- FSM has two states:
  - S_BOOT: entered on rst. imem_req_valid=0. Moves to S_RUN after one cycle.
  - S_RUN: normal operation.
- Reset values (held while rst=1 and in the first cycle after rst falls):
  - pc = rsp_pc = RESET_PC.
  - outstanding = drop_cnt = 0; FIFO empty.
  - imem_req_valid = 0, inst_valid = 0.
  - imem_req_addr = RESET_PC; inst_data = 0; inst_pc = 0.
- Request issue:
  - imem_req_valid = (state==S_RUN) && !redirect_valid && (outstanding + count < FIFO_DEPTH).
  - Credit is computed from registered values only; a same-cycle FIFO pop does not free credit.
  - On req handshake: pc += 4, wrapping modulo 2^WIDTH; outstanding += 1.
  - imem_req_valid and imem_req_addr are held stable until the handshake or a redirect.
- Response handling:
  - On imem_rsp_valid: outstanding -= 1.
  - If drop_cnt > 0 or redirect_valid: the word is discarded; drop_cnt decrements if it was nonzero.
  - Otherwise: write {imem_rsp_data, rsp_pc} to the FIFO and rsp_pc += 4.
  - FIFO overflow cannot occur because of the credit rule. A response arriving with outstanding==0 is a protocol error; ignore it and do not underflow the counter.
- Output:
  - inst_valid = (count != 0) && !redirect_valid.
  - inst_data and inst_pc come from the registered FIFO head.
  - Pop on inst_valid && inst_ready. Push and pop in the same cycle leaves count unchanged.
- Latency: a request accepted in cycle N with its response in N+1 gives inst_valid in N+2.
- Throughput: one instruction per cycle in steady state with FIFO_DEPTH ≥ 4, a 1-cycle memory and inst_ready=1.
- Redirect (takes effect at the clock edge where redirect_valid=1):
  - pc = rsp_pc = {redirect_pc[WIDTH-1:2], 2'b00}.
  - FIFO flushed: count = 0, pointers reset.
  - drop_cnt = outstanding after this cycle's response decrement.
  - A response in the redirect cycle is itself dropped.
  - No request is issued and no pop occurs in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Reset mid-operation: all state returns to reset values. In-flight memory responses arriving during or after reset are the memory's responsibility, since the memory is reset by the same rst.

Test Plan:
- Release rst, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000, inst_ready=1:
  - first request has addr 0x0 one cycle after rst falls.
  - inst_valid rises two cycles later with inst_pc 0x0, inst_data 0xA5A5_0000.
  - inst_pc then increments by 4 every cycle.
- Hold inst_ready=0 with FIFO_DEPTH=4:
  - exactly 4 requests are accepted, then imem_req_valid=0.
  - the FIFO holds PCs 0x0, 0x4, 0x8, 0xC.
  - raising inst_ready drains them in order and fetching resumes at 0x10.
- Memory latency 3 cycles, 2 requests in flight, redirect_valid with redirect_pc=0x103:
  - both stale responses are discarded and the FIFO is empty the next cycle.
  - the next request has addr 0x100, and the first delivered inst_pc is 0x100.
- Redirect in the same cycle as a response and an inst_ready handshake:
  - the response is dropped and no pop is counted.
  - inst_valid=0 that cycle.
  - the post-redirect stream starts at the target.
- RESET_PC=32'hFFFF_FFF8:
  - requests go to 0xFFFF_FFF8, then 0xFFFF_FFFC, then 0x0000_0000.
  - inst_pc wraps identically.
- Assert rst with 3 FIFO entries and 1 outstanding request:
  - the next cycle has inst_valid=0 and imem_req_valid=0.
  - after release, fetch restarts at RESET_PC.
